// File: rtl/wlm_sched_if.sv
// Handshake bundle between wlm_sched and its requesters, reduction unit and result consumer.
interface wlm_sched_if #(
  parameter int LOGQ    = 60,
  parameter int QH_MODE = 1,
  parameter int N_REQ   = 4
);
  localparam int K     = 2 * LOGQ;
  localparam int LOGQH = (QH_MODE == 0) ? 26 : 17;
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]       req_valid;
  logic [N_REQ-1:0]       req_ready;
  logic [N_REQ*K-1:0]     req_C;
  logic [N_REQ*LOGQH-1:0] req_qH;
  logic [K-1:0]           dp_C;
  logic [LOGQH-1:0]       dp_qH;
  logic                   dp_issue;
  logic [LOGQ-1:0]        dp_T;
  logic                   res_valid;
  logic                   res_ready;
  logic [LOGQ-1:0]        res_T;
  logic [IDW-1:0]         res_id;
  logic                   busy;

  modport slave (
    input  req_valid, req_C, req_qH, dp_T, res_ready,
    output req_ready, dp_C, dp_qH, dp_issue, res_valid, res_T, res_id, busy
  );

  modport master (
    output req_valid, req_C, req_qH, dp_T, res_ready,
    input  req_ready, dp_C, dp_qH, dp_issue, res_valid, res_T, res_id, busy
  );
endinterface

// File: rtl/wlm_sched.sv
// Round-robin scheduler sharing one fixed-latency reduction unit among N_REQ requesters,
// with in-order result return through a credit-protected first-word-fall-through FIFO.
module wlm_sched #(
  parameter int LOGQ       = 60,
  parameter int QH_MODE    = 1,
  parameter int N_REQ      = 4,
  parameter int LAT        = 8,
  parameter int FIFO_DEPTH = 16
) (
  input logic        clk,
  input logic        rst,
  wlm_sched_if.slave bus
);
  localparam int K     = 2 * LOGQ;
  localparam int LOGQH = (QH_MODE == 0) ? 26 : 17;
  localparam int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int EW    = IDW + LOGQ;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  inflight_q, inflight_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [AW-1:0]  wr_q, rd_q;
  logic [LAT-1:0] tv_q;
  logic [IDW-1:0] tid_q [LAT];
  logic [EW-1:0]  mem_q [FIFO_DEPTH];

  logic           can_issue, grant, push, pop;
  logic [IDW-1:0] gid, cand;
  logic [CW:0]    credit_used;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return IDW'(s);
  endfunction

  // Pops in the current cycle are deliberately not credited back until they land in cnt_q.
  assign credit_used = {1'b0, inflight_q} + {1'b0, cnt_q};
  assign can_issue   = credit_used < (CW+1)'(FIFO_DEPTH);

  always_comb begin
    grant = 1'b0;
    gid   = '0;
    cand  = '0;
    if (can_issue && !rst) begin
      for (int k = N_REQ - 1; k >= 0; k--) begin
        cand = wrap_add(ptr_q, k);
        if (bus.req_valid[cand]) begin
          grant = 1'b1;
          gid   = cand;
        end
      end
    end
  end

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
    assign bus.req_ready[gi] = grant && (gid == IDW'(gi));
  end

  assign bus.dp_issue = grant;
  assign bus.dp_C     = grant ? bus.req_C[int'(gid)*K +: K] : '0;
  assign bus.dp_qH    = grant ? bus.req_qH[int'(gid)*LOGQH +: LOGQH] : '0;

  assign push = tv_q[LAT-1];
  assign pop  = (cnt_q != '0) && bus.res_ready;

  always_comb begin
    ptr_d      = grant ? wrap_add(gid, 1) : ptr_q;
    inflight_d = inflight_q;
    if (grant && !push) inflight_d = inflight_q + CW'(1);
    else if (!grant && push) inflight_d = inflight_q - CW'(1);
    cnt_d = cnt_q;
    if (push && !pop) cnt_d = cnt_q + CW'(1);
    else if (pop && !push) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q      <= '0;
      inflight_q <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      tv_q       <= '0;
    end else begin
      ptr_q      <= ptr_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      if (push) wr_q <= wr_q + AW'(1);
      if (pop)  rd_q <= rd_q + AW'(1);
      tv_q[0] <= grant;
      for (int k = 1; k < LAT; k++) tv_q[k] <= tv_q[k-1];
    end
  end

  // Ids travel without reset; only the valid bits decide whether dp_T is captured.
  always_ff @(posedge clk) begin
    tid_q[0] <= gid;
    for (int k = 1; k < LAT; k++) tid_q[k] <= tid_q[k-1];
    if (push) mem_q[wr_q] <= {tid_q[LAT-1], bus.dp_T};
  end

  assign bus.res_valid = (cnt_q != '0);
  assign bus.res_T     = mem_q[rd_q][LOGQ-1:0];
  assign bus.res_id    = mem_q[rd_q][EW-1:LOGQ];
  assign bus.busy      = (inflight_q != '0) || (cnt_q != '0);

  a_no_full_push : assert property (@(posedge clk) disable iff (rst)
                                    !(push && (cnt_q == CW'(FIFO_DEPTH))));
endmodule

// File: tb/tb_wlm_sched.sv
// Randomized directed bench for wlm_sched: a queue-based model predicts grants, credit,
// result timing, ordering and data; a behavioural stand-in provides the reduction unit.
module tb_wlm_sched;
  localparam int LOGQ       = 60;
  localparam int QH_MODE    = 1;
  localparam int N_REQ      = 4;
  localparam int LAT        = 8;
  localparam int FIFO_DEPTH = 16;
  localparam int K          = 2 * LOGQ;
  localparam int LOGQH      = (QH_MODE == 0) ? 26 : 17;
  localparam int IDW        = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wlm_sched_if #(.LOGQ(LOGQ), .QH_MODE(QH_MODE), .N_REQ(N_REQ)) bus ();

  wlm_sched #(
    .LOGQ(LOGQ), .QH_MODE(QH_MODE), .N_REQ(N_REQ), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Stand-in arithmetic for the reduction unit; idle cycles still produce nonzero junk.
  function automatic logic [LOGQ-1:0] unit_fn(input logic [K-1:0] c, input logic [LOGQH-1:0] qh);
    logic [K-1:0] acc;
    acc = (c >> LOGQ) + K'(c[LOGQ-1:0]) * K'(qh) + K'(1234567);
    return acc[LOGQ-1:0];
  endfunction

  logic [LOGQ-1:0] dp_pipe [LAT];
  always @(posedge clk) begin
    dp_pipe[0] <= unit_fn(bus.dp_C, bus.dp_qH);
    for (int k = 1; k < LAT; k++) dp_pipe[k] <= dp_pipe[k-1];
  end
  assign bus.dp_T = dp_pipe[LAT-1];

  typedef struct {
    int              id;
    logic [LOGQ-1:0] t;
    int              rdy;
  } ent_t;

  ent_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc_no = 0;
  int   ptr    = 0;

  task automatic chk(input string tag, input logic [K-1:0] got, input logic [K-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h cycle %0d", tag, got, exp, cyc_no);
    end
  endtask

  function automatic logic [K-1:0] rand_c();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 7) == 0) r = '1;
    return r[K-1:0];
  endfunction

  // One clock cycle: drive, predict, compare, then advance the model.
  task automatic cyc(input logic [N_REQ-1:0] vmask, input logic rr);
    logic [K-1:0]     cv [N_REQ];
    logic [LOGQH-1:0] qv [N_REQ];
    logic [N_REQ-1:0] er;
    logic             hv;
    int               g;
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      cv[i] = rand_c();
      qv[i] = LOGQH'($urandom);
      bus.req_C[i*K +: K]          = cv[i];
      bus.req_qH[i*LOGQH +: LOGQH] = qv[i];
    end
    bus.req_valid = vmask;
    bus.res_ready = rr;
    @(negedge clk);
    g = -1;
    if (exp_q.size() < FIFO_DEPTH) begin
      for (int k = 0; k < N_REQ; k++) begin
        if (g < 0 && vmask[(ptr + k) % N_REQ]) g = (ptr + k) % N_REQ;
      end
    end
    er = '0;
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", K'(bus.req_ready), K'(er));
    chk("dp_issue", K'(bus.dp_issue), K'(g >= 0));
    chk("dp_C", bus.dp_C, (g >= 0) ? cv[g] : '0);
    chk("dp_qH", K'(bus.dp_qH), (g >= 0) ? K'(qv[g]) : '0);
    hv = (exp_q.size() > 0) && (exp_q[0].rdy <= cyc_no);
    chk("res_valid", K'(bus.res_valid), K'(hv));
    if (hv) begin
      chk("res_T", K'(bus.res_T), K'(exp_q[0].t));
      chk("res_id", K'(bus.res_id), K'(exp_q[0].id));
    end
    chk("busy", K'(bus.busy), K'(exp_q.size() != 0));
    if (hv && rr) void'(exp_q.pop_front());
    if (g >= 0) begin
      exp_q.push_back('{id: g, t: unit_fn(cv[g], qv[g]), rdy: cyc_no + LAT + 1});
      ptr = (g + 1) % N_REQ;
    end
    cyc_no++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid = '0;
    bus.req_C     = '0;
    bus.req_qH    = '0;
    bus.res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.req_valid = '1;
    #1;
    chk("reset_req_ready", K'(bus.req_ready), '0);
    chk("reset_res_valid", K'(bus.res_valid), '0);
    chk("reset_busy", K'(bus.busy), '0);
    chk("reset_dp_issue", K'(bus.dp_issue), '0);
    @(negedge clk);
    bus.req_valid = '0;
    rst = 1'b0;

    // single op from requester 2
    cyc(4'b0100, 1'b1);
    repeat (LAT + 4) cyc('0, 1'b1);

    // round robin at full rate
    repeat (20) cyc(4'b1111, 1'b1);
    repeat (LAT + 2) cyc('0, 1'b1);

    // backpressure: credit exhausted, then drain while requesting
    repeat (24) cyc(4'b0001, 1'b0);
    repeat (30) cyc(4'b0001, 1'b1);
    repeat (LAT + 2) cyc('0, 1'b1);

    // credit boundary: FIFO holds DEPTH-LAT, then LAT more in flight
    repeat (FIFO_DEPTH - LAT) cyc(4'b0001, 1'b0);
    repeat (LAT + 2) cyc('0, 1'b0);
    repeat (LAT + 4) cyc(4'b0001, 1'b0);
    repeat (3) cyc(4'b0001, 1'b1);
    repeat (FIFO_DEPTH + LAT + 4) cyc('0, 1'b1);

    // reset with 3 buffered and 5 in flight
    repeat (3) cyc(4'b0001, 1'b0);
    repeat (4) cyc('0, 1'b0);
    repeat (5) cyc(4'b0001, 1'b0);
    @(posedge clk);
    #1 bus.req_valid = '0;
    bus.res_ready = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("midrst_res_valid", K'(bus.res_valid), '0);
    chk("midrst_busy", K'(bus.busy), '0);
    exp_q.delete();
    ptr = 0;
    @(posedge clk);
    #1 bus.req_valid = '1;
    #1;
    chk("midrst_req_ready", K'(bus.req_ready), '0);
    @(posedge clk);
    #2 bus.req_valid = '0;
    rst = 1'b0;
    repeat (LAT + 3) cyc('0, 1'b1);
    cyc(4'b0010, 1'b1);
    repeat (LAT + 3) cyc('0, 1'b1);

    // sparse and skewed traffic
    repeat (60) cyc(($urandom_range(0, 1) != 0) ? 4'b1000 : 4'b0000, $urandom_range(0, 3) != 0);
    cyc(4'b1111, 1'b1);
    repeat (60) cyc(($urandom_range(0, 1) != 0) ? 4'b0010 : 4'b0000, $urandom_range(0, 3) != 0);
    cyc(4'b1111, 1'b1);
    repeat (100) cyc(N_REQ'($urandom), $urandom_range(0, 1) != 0);
    repeat (FIFO_DEPTH + LAT + 4) cyc('0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
